// File: rtl/dfu_pkg.sv
// ============================================================================
// Module   : dfu_pkg
// Purpose  : Shared DFU state codes, LED mode enum, colour masks and the
//            state-to-mode decoder used by the status LED block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dfu_pkg;

  // DFU state codes as reported by usb_dfu_core
  localparam logic [7:0] APP_IDLE                = 8'd0;
  localparam logic [7:0] APP_DETACH              = 8'd1;
  localparam logic [7:0] DFU_IDLE                = 8'd2;
  localparam logic [7:0] DFU_DNLOAD_SYNC         = 8'd3;
  localparam logic [7:0] DFU_DNBUSY              = 8'd4;
  localparam logic [7:0] DFU_DNLOAD_IDLE         = 8'd5;
  localparam logic [7:0] DFU_MANIFEST_SYNC       = 8'd6;
  localparam logic [7:0] DFU_MANIFEST            = 8'd7;
  localparam logic [7:0] DFU_MANIFEST_WAIT_RESET = 8'd8;
  localparam logic [7:0] DFU_UPLOAD_IDLE         = 8'd9;
  localparam logic [7:0] DFU_ERROR               = 8'd10;

  // LED indication modes; MODE_OFF is only produced by a detach request
  typedef enum logic [2:0] {
    MODE_APP      = 3'd0,
    MODE_IDLE     = 3'd1,
    MODE_DNLOAD   = 3'd2,
    MODE_MANIFEST = 3'd3,
    MODE_UPLOAD   = 3'd4,
    MODE_ERROR    = 3'd5,
    MODE_OFF      = 3'd6
  } led_mode_e;

  // Colour masks, bit order {r, g, b}
  localparam logic [2:0] COL_OFF     = 3'b000;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_MAGENTA = 3'b101;

  // Map a DFU state code to an indication mode; unknown codes are errors
  function automatic led_mode_e decode_mode(input logic [7:0] code);
    led_mode_e m;
    case (code)
      APP_IDLE, APP_DETACH:                  m = MODE_APP;
      DFU_IDLE:                              m = MODE_IDLE;
      DFU_DNLOAD_SYNC, DFU_DNBUSY,
      DFU_DNLOAD_IDLE:                       m = MODE_DNLOAD;
      DFU_MANIFEST_SYNC, DFU_MANIFEST,
      DFU_MANIFEST_WAIT_RESET:               m = MODE_MANIFEST;
      DFU_UPLOAD_IDLE:                       m = MODE_UPLOAD;
      DFU_ERROR:                             m = MODE_ERROR;
      default:                               m = MODE_ERROR;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_breathe.sv
// ============================================================================
// Module   : led_breathe
// Purpose  : Triangle "breathing" envelope generator. A step counter paces a
//            PWM_W-bit envelope that ramps up, holds one step at the top,
//            ramps down and holds one step at zero. Output is the PWM duty.
//            Macro STATUS_LED_GAMMA_EN selects a registered squared duty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_breathe #(
  parameter int PWM_W       = 8,
  parameter int STEP_CYCLES = 23438
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [PWM_W-1:0] duty
);

  localparam int               STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_W-1:0]  ENV_MAX   = '1;
  localparam logic              DIR_UP    = 1'b0;
  localparam logic              DIR_DOWN  = 1'b1;

  logic [STEP_W-1:0] step_cnt;
  logic [PWM_W-1:0]  env;
  logic              env_dir;

  // Step pacing and envelope: one envelope move (or end-point hold) per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      env      <= '0;
      env_dir  <= DIR_UP;
    end else if (clear) begin
      step_cnt <= '0;
      env      <= '0;
      env_dir  <= DIR_UP;
    end else if (step_cnt == STEP_LAST) begin
      step_cnt <= '0;
      if (env_dir == DIR_UP) begin
        if (env == ENV_MAX) env_dir <= DIR_DOWN;
        else                env     <= env + PWM_W'(1);
      end else begin
        if (env == '0) env_dir <= DIR_UP;
        else           env     <= env - PWM_W'(1);
      end
    end else begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

`ifdef STATUS_LED_GAMMA_EN
  logic [2*PWM_W-1:0] env_sq;
  logic [PWM_W-1:0]   duty_q;

  assign env_sq = {{PWM_W{1'b0}}, env} * {{PWM_W{1'b0}}, env};

  // Squared envelope, registered to keep the multiplier off the output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     duty_q <= '0;
    else if (clear) duty_q <= '0;
    else            duty_q <= env_sq[2*PWM_W-1:PWM_W];
  end

  assign duty = duty_q;
`else
  assign duty = env;
`endif

endmodule

`default_nettype wire

// File: rtl/dfu_status_led.sv
// ============================================================================
// Module   : dfu_status_led
// Purpose  : RGB status LED driver for the DFU bootloader. Decodes the DFU
//            state into a colour pattern (dim solid, breathing, blinking,
//            full solid) and produces registered PWM drives plus the LED
//            driver enable. Optional macro STATUS_LED_GAMMA_EN squares the
//            breathing duty for a perceptually smoother ramp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfu_status_led
  import dfu_pkg::*;
#(
  parameter int PWM_W        = 8,
  parameter int STEP_CYCLES  = 23438,
  parameter int BLINK_CYCLES = 3000000,
  parameter int DIM_DUTY     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dfu_state,
  input  logic       dfu_detach,
  output logic       stat_r,
  output logic       stat_g,
  output logic       stat_b,
  output logic       stat_en
);

  localparam int                 FAST_HALF = (BLINK_CYCLES / 4 > 0) ? BLINK_CYCLES / 4 : 1;
  localparam int                 BLINK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF - 1);
  localparam logic [PWM_W-1:0]   DIM_LEVEL = PWM_W'(DIM_DUTY);
  localparam logic               PH_ON     = 1'b0;

  logic [7:0]         state_q;
  led_mode_e          mode;
  led_mode_e          mode_q;
  led_mode_e          out_mode;
  logic               mode_chg;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_last;
  logic               blink_ph;
  logic               blink_on;
  logic [PWM_W-1:0]   duty_raw;
  logic [PWM_W-1:0]   breathe_duty;
  logic [2:0]         colour;

  assign mode     = decode_mode(state_q);
  assign mode_chg = (mode != mode_q);
  assign out_mode = dfu_detach ? MODE_OFF : mode;

  // On a mode change the pattern restarts, so the first output already shows
  // the restarted phase (blink on, envelope at zero) to keep latency at 2.
  assign blink_on     = mode_chg || (blink_ph == PH_ON);
  assign breathe_duty = mode_chg ? '0 : duty_raw;
  assign blink_last   = (mode == MODE_ERROR) ? FAST_LAST : SLOW_LAST;

  // Input stage register and last-seen mode for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      mode_q  <= MODE_APP;
    end else begin
      state_q <= dfu_state;
      mode_q  <= mode;
    end
  end

  // Free-running PWM period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  // Blink half-period timer and phase, restarted on every mode change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= PH_ON;
    end else if (mode_chg) begin
      blink_cnt <= '0;
      blink_ph  <= PH_ON;
    end else if (blink_cnt == blink_last) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  led_breathe #(
    .PWM_W       (PWM_W),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_breathe (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mode_chg),
    .duty  (duty_raw)
  );

  // Per-mode colour selection; "full" colours bypass the PWM compare
  always_comb begin
    colour = COL_OFF;
    case (out_mode)
      MODE_APP:      colour = (pwm_cnt < DIM_LEVEL)    ? COL_GREEN   : COL_OFF;
      MODE_IDLE:     colour = (pwm_cnt < breathe_duty) ? COL_MAGENTA : COL_OFF;
      MODE_DNLOAD:   colour = blink_on ? COL_BLUE  : COL_OFF;
      MODE_MANIFEST: colour = COL_GREEN;
      MODE_UPLOAD:   colour = blink_on ? COL_GREEN : COL_OFF;
      MODE_ERROR:    colour = blink_on ? COL_RED   : COL_OFF;
      default:       colour = COL_OFF;
    endcase
  end

  // Registered LED drives; detach blanks colour and driver enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r  <= 1'b0;
      stat_g  <= 1'b0;
      stat_b  <= 1'b0;
      stat_en <= 1'b0;
    end else begin
      stat_r  <= colour[2];
      stat_g  <= colour[1];
      stat_b  <= colour[0];
      stat_en <= (out_mode != MODE_OFF);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dfu_status_led.sv
// ============================================================================
// Module   : tb_dfu_status_led
// Purpose  : Self-checking bench for dfu_status_led. Stimulus pushes expected
//            output counts over edge windows into a scoreboard; a monitor
//            records outputs each falling edge and retires windows as they
//            complete. Honours STATUS_LED_GAMMA_EN for breathing expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dfu_status_led;

  localparam int PWM_W = 8;
  localparam int STEP  = 4;
  localparam int BLINK = 100;
  localparam int DIM   = 32;
  localparam int HMAX  = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dfu_state = 8'd0;
  logic       dfu_detach = 1'b0;
  logic       stat_r, stat_g, stat_b, stat_en;

  dfu_status_led #(
    .PWM_W        (PWM_W),
    .STEP_CYCLES  (STEP),
    .BLINK_CYCLES (BLINK),
    .DIM_DUTY     (DIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dfu_state  (dfu_state),
    .dfu_detach (dfu_detach),
    .stat_r     (stat_r),
    .stat_g     (stat_g),
    .stat_b     (stat_b),
    .stat_en    (stat_en)
  );

  always #5 clk = ~clk;

  // Rising-edge index; outputs sampled after edge N are stored at hist[N]
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  bit hist_r [HMAX];
  bit hist_g [HMAX];
  bit hist_b [HMAX];
  bit hist_e [HMAX];

  typedef struct {
    string name;
    int    at;
    int    len;
    int    r, g, b, en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   rel_edge = 0;  // last reset-release edge: pwm_cnt is 0 after it

  int E0, E1, E2, E3, E4, D, F, G;

  task automatic expect_win(input string name, input int at, input int len,
                            input int r, input int g, input int b, input int en);
    exp_t it;
    it.name = name; it.at = at; it.len = len;
    it.r = r; it.g = g; it.b = b; it.en = en;
    sb.push_back(it);
  endtask

  // Breathing reference: envelope value after edge e, IDLE entered by an
  // input change right after edge e0 (mode change lands on edge e0+2).
  function automatic int env_after(input int e0, input int e);
    int k, t;
    if (e < e0 + 2) return 0;
    k = (e - e0 - 2) / STEP;
    t = k % 512;
    return (t <= 255) ? t : 511 - t;
  endfunction

  function automatic int duty_at(input int e0, input int e);
`ifdef STATUS_LED_GAMMA_EN
    int v;
    v = env_after(e0, e - 2);
    return (v * v) >> 8;
`else
    return env_after(e0, e - 1);
`endif
  endfunction

  function automatic int idle_on(input int e0, input int e);
    int pwm;
    pwm = (e - 1 - rel_edge) % 256;
    return (pwm < duty_at(e0, e)) ? 1 : 0;
  endfunction

  task automatic expect_idle(input string name, input int e0, input int from, input int len);
    int s;
    s = 0;
    for (int e = from; e < from + len; e++) s += idle_on(e0, e);
    expect_win(name, from, len, s, 0, s, len);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (edges < target) step(1);
  endtask

  // Monitor: record outputs, retire completed windows
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (edges < HMAX) begin
        hist_r[edges] = stat_r;
        hist_g[edges] = stat_g;
        hist_b[edges] = stat_b;
        hist_e[edges] = stat_en;
      end
      while (sb.size() > 0 && (sb[0].at + sb[0].len - 1) <= edges) begin
        exp_t it;
        int cr, cg, cb, ce;
        it = sb.pop_front();
        cr = 0; cg = 0; cb = 0; ce = 0;
        for (int i = it.at; i < it.at + it.len; i++) begin
          if (i >= 0 && i < HMAX) begin
            cr += int'(hist_r[i]);
            cg += int'(hist_g[i]);
            cb += int'(hist_b[i]);
            ce += int'(hist_e[i]);
          end
        end
        checks++;
        if (cr == it.r && cg == it.g && cb == it.b && ce == it.en) begin
          passed++;
        end else begin
          $display("FAIL %s @edge %0d len %0d: got r/g/b/en=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   it.name, it.at, it.len, cr, cg, cb, ce, it.r, it.g, it.b, it.en);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;

    // Reset and APP dim green
    step(3);
    expect_win("reset_state", edges, 1, 0, 0, 0, 0);
    rel_edge = edges;
    rst_n = 1'b1;
    expect_win("en_first_edge", rel_edge + 1, 1, 0, 1, 0, 1);
    expect_win("app_dim_window", rel_edge + 1, 256, 0, DIM, 0, 256);
    step(300);

    // IDLE breathing over a full triangle and into the next
    E0 = edges;
    dfu_state = 8'd2;
    expect_win("idle_entry_off", E0 + 2, 1, 0, 0, 0, 1);
    expect_idle("idle_ramp_start", E0, E0 + 3, 256);
    expect_idle("idle_ramp_mid", E0, E0 + 700, 256);
    expect_idle("idle_peak", E0, E0 + 1000, 256);
    expect_idle("idle_ramp_down", E0, E0 + 1500, 256);
    expect_idle("idle_bottom", E0, E0 + 1950, 256);
    expect_idle("idle_second_ramp", E0, E0 + 2100, 256);
    step_to(E0 + 2400);

    // Detach pulse: blank for one edge, counters keep running
    D = edges;
    dfu_detach = 1'b1;
    step(1);
    dfu_detach = 1'b0;
    expect_win("detach_off", D + 1, 1, 0, 0, 0, 0);
    expect_idle("detach_release", E0, D + 2, 1);
    expect_idle("detach_counters_run", E0, D + 2, 256);

    // Mid-ramp (env=100 on the second descent) switch to MANIFEST and back
    step_to(E0 + 3694);
    E1 = edges;
    dfu_state = 8'd7;
    expect_idle("manifest_latency_old", E0, E1 + 1, 1);
    expect_win("manifest_solid", E1 + 2, 40, 0, 40, 0, 40);
    step(60);
    E2 = edges;
    dfu_state = 8'd2;
    expect_win("idle_return_latency", E2 + 1, 1, 0, 1, 0, 1);
    expect_win("idle_restart_off", E2 + 2, 1, 0, 0, 0, 1);
    expect_idle("idle_restart_env0", E2, E2 + 3, 256);
    step(300);

    // DNLOAD blue blink, 100-clock half periods
    E3 = edges;
    dfu_state = 8'd4;
    expect_win("dnload_latency", E3 + 2, 1, 0, 0, 1, 1);
    expect_win("dnload_on0", E3 + 3, 100, 0, 0, 100, 100);
    expect_win("dnload_off1", E3 + 103, 100, 0, 0, 0, 100);
    expect_win("dnload_on1", E3 + 203, 100, 0, 0, 100, 100);
    expect_win("dnload_off2", E3 + 303, 100, 0, 0, 0, 100);
    step(450);

    // ERROR red fast blink, then unknown code 0x55 keeps the same pattern
    E4 = edges;
    dfu_state = 8'd10;
    expect_win("err_on0", E4 + 2, 26, 26, 0, 0, 26);
    expect_win("err_off1", E4 + 28, 25, 0, 0, 0, 25);
    expect_win("err_on1", E4 + 53, 25, 25, 0, 0, 25);
    step_to(E4 + 80);
    dfu_state = 8'h55;
    expect_win("err55_off", E4 + 128, 25, 0, 0, 0, 25);
    expect_win("err55_on", E4 + 153, 25, 25, 0, 0, 25);
    expect_win("err55_off2", E4 + 178, 25, 0, 0, 0, 25);
    step_to(E4 + 215);

    // Async reset in an ERROR on phase (on: E4+203..E4+227)
    F = edges;
    expect_win("err_before_reset", F - 1, 1, 1, 0, 0, 1);
    #1;
    rst_n = 1'b0;
    expect_win("async_reset_off", F, 1, 0, 0, 0, 0);
    step(3);
    G = edges;
    rst_n = 1'b1;
    rel_edge = G;
    expect_win("reset_hold_en", G, 1, 0, 0, 0, 0);
    expect_win("en_after_release", G + 1, 1, 0, 1, 0, 1);
    step(10);

    guard = 0;
    while (sb.size() > 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
